// File: rtl/ahb_bus_matrix_decoder_param.sv
// AHB bus-matrix output-stage decoder.
// Decodes HADDR[31:10] into a one-hot per-port HSEL, remembers the data-phase
// port, muxes that port's response back to the input stage, and provides an
// internal default slave (OKAY for IDLE/BUSY, two-cycle ERROR otherwise) for
// unmapped addresses, with a saturating count of decode errors.
// Region parameters pack one 22-bit value per port, port 0 in the LSBs; the
// defaults map port 0 to 0x000..0x07f and port 1 to 0x080..0x0ff.
module ahb_bus_matrix_decoder_param #(
    parameter int unsigned               NUM_PORTS    = 2,
    parameter int unsigned               DW           = 32,
    parameter int unsigned               UW           = 32,
    parameter logic [22*NUM_PORTS-1:0]   REGION_BASE  = {22'h000080, 22'h000000},
    parameter logic [22*NUM_PORTS-1:0]   REGION_LIMIT = {22'h0000ff, 22'h00007f}
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HREADYS,
    input  logic                    sel_dec,
    input  logic [21:0]             decode_addr_dec,
    input  logic [1:0]              trans_dec,
    input  logic [NUM_PORTS-1:0]    active_dec_i,
    input  logic [NUM_PORTS-1:0]    readyout_dec_i,
    input  logic [2*NUM_PORTS-1:0]  resp_dec_i,
    input  logic [DW*NUM_PORTS-1:0] rdata_dec_i,
    input  logic [UW*NUM_PORTS-1:0] ruser_dec_i,
    input  logic                    err_clr,
    output logic [NUM_PORTS-1:0]    sel_dec_o,
    output logic                    active_dec,
    output logic                    HREADYOUTS,
    output logic [1:0]              HRESPS,
    output logic [DW-1:0]           HRDATAS,
    output logic [UW-1:0]           HRUSERS,
    output logic [7:0]              err_count
);

    // Port index width covers 0..NUM_PORTS; index NUM_PORTS is the default slave.
    localparam int unsigned   PW  = $clog2(NUM_PORTS + 1);
    localparam logic [PW-1:0] DFT = PW'(NUM_PORTS);

    typedef enum logic [1:0] {
        DS_OK   = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    logic [PW-1:0] addr_port;
    logic          region_hit;
    logic          sel_dft;
    logic [PW-1:0] data_port_q, data_port_d;
    ds_state_e     ds_q, ds_d;
    logic          dft_ready;
    logic [1:0]    dft_resp;
    logic [7:0]    err_count_q, err_count_d;

    // Address-phase decode: IDLE keeps the current data-phase port, otherwise lowest matching region wins.
    always_comb begin
        addr_port  = DFT;
        region_hit = 1'b0;
        if (trans_dec == 2'b00 && data_port_q != DFT) begin
            addr_port = data_port_q;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (!region_hit &&
                    decode_addr_dec >= REGION_BASE[22*p +: 22] &&
                    decode_addr_dec <= REGION_LIMIT[22*p +: 22]) begin
                    addr_port  = PW'(p);
                    region_hit = 1'b1;
                end
            end
        end
    end

    // Per-port selects and the active flag of the addressed port.
    always_comb begin
        sel_dec_o  = '0;
        active_dec = 1'b1;
        sel_dft    = sel_dec && (addr_port == DFT);
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            sel_dec_o[p] = sel_dec && (addr_port == PW'(p));
            if (addr_port == PW'(p)) begin
                active_dec = active_dec_i[p];
            end
        end
    end

    // Data-phase port advances only when the bus is ready.
    always_comb begin
        data_port_d = HREADYS ? addr_port : data_port_q;
    end

    // Default-slave next state and its response outputs.
    always_comb begin
        ds_d      = DS_OK;
        dft_ready = 1'b1;
        dft_resp  = 2'b00;
        case (ds_q)
            DS_OK, DS_ERR2: begin
                if (sel_dft && HREADYS && trans_dec[1]) begin
                    ds_d = DS_ERR1;
                end
                if (ds_q == DS_ERR2) begin
                    dft_resp = 2'b01;
                end
            end
            DS_ERR1: begin
                ds_d      = DS_ERR2;
                dft_ready = 1'b0;
                dft_resp  = 2'b01;
            end
            default: ds_d = DS_OK;
        endcase
    end

    // Error counter: clear wins over a simultaneous increment; increments saturate.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (ds_d == DS_ERR1 && ds_q != DS_ERR1 && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_port_q <= '0;
            ds_q        <= DS_OK;
            err_count_q <= '0;
        end else begin
            data_port_q <= data_port_d;
            ds_q        <= ds_d;
            err_count_q <= err_count_d;
        end
    end

    // Zero-latency response mux by data-phase port; the default slave returns zero data.
    always_comb begin
        HREADYOUTS = dft_ready;
        HRESPS     = dft_resp;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (data_port_q == PW'(p)) begin
                HREADYOUTS = readyout_dec_i[p];
                HRESPS     = resp_dec_i[2*p +: 2];
                HRDATAS    = rdata_dec_i[DW*p +: DW];
                HRUSERS    = ruser_dec_i[UW*p +: UW];
            end
        end
    end

    assign err_count = err_count_q;

endmodule
